// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: shared definitions for the RAM-backed FIFO controller.
//   - Default word and address widths for the 32x16 single-port RAM.
//   - Read-sequencer state encoding (ST_IDLE=1'b0, ST_RD_WAIT=1'b1).
package ram_fifo_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 5;

    // Read sequencer: IDLE may issue a read, RD_WAIT waits for the RAM's registered data.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a single-port RAM (registered read data) into a
// synchronous FIFO with valid/ready push and pop interfaces plus a one-entry
// output register holding the head word.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   push_valid/data/ready    producer side; push_ready is low while a read owns the RAM
//   pop_valid/data/ready     consumer side; pop_data is registered
//   count, full, empty       occupancy (RAM + in-flight read + output register)
//   ram_address/data_in/
//   ram_wrenable/rdenable    RAM control, at most one strobe per cycle
//   ram_data_out             RAM read data, valid the cycle after rdenable
//
// Optional build macro RAM_FIFO_STATS_EN adds:
//   overflow                 sticky flag, set by push_valid while full
//   max_count                peak value of count since reset
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    input  logic              pop_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wrenable,
    output logic              ram_rdenable,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_FIFO_STATS_EN
    ,
    output logic              overflow,
    output logic [ADDR_W:0]   max_count
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  ram_cnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    state_t            state;

    logic pop_fire;
    logic rd_issue;
    logic wr_fire;

    // Handshakes. A read is issued whenever the output register is free (or
    // being emptied this cycle) and the RAM holds data; it takes priority
    // over a write for the single RAM port.
    assign pop_fire   = out_valid & pop_ready;
    assign rd_issue   = !rst && (state == ST_IDLE) && (ram_cnt != '0) &&
                        (!out_valid || pop_fire);
    assign full       = (ram_cnt == CNT_W'(DEPTH));
    assign push_ready = !rst && !full && !rd_issue;
    assign wr_fire    = push_valid & push_ready;

    // Occupancy counts the word in flight from the RAM as well as the output register.
    assign count = ram_cnt + CNT_W'(state == ST_RD_WAIT) + CNT_W'(out_valid);
    assign empty = (count == '0);

    assign pop_valid = out_valid;
    assign pop_data  = out_data;

    // RAM port: read address wins when a read is issued; parked at 0 in reset.
    assign ram_wrenable = wr_fire;
    assign ram_rdenable = rd_issue;
    assign ram_data_in  = push_data;
    assign ram_address  = rst      ? '0     :
                          rd_issue ? rd_ptr : wr_ptr;

    // Pointers, RAM occupancy, read sequencer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            state     <= ST_IDLE;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            ram_cnt <= ram_cnt + CNT_W'(wr_fire) - CNT_W'(rd_issue);

            case (state)
                ST_IDLE: begin
                    if (rd_issue) begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A refill landing on the same edge as a pop keeps the register valid.
            if (state == ST_RD_WAIT) begin
                out_valid <= 1'b1;
                out_data  <= ram_data_out;
            end else if (pop_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RAM_FIFO_STATS_EN
    // Sticky overflow attempt flag and peak occupancy tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            max_count <= '0;
        end else begin
            if (push_valid && full) begin
                overflow <= 1'b1;
            end
            if (count > max_count) begin
                max_count <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl with a behavioural
// 32x16 RAM beside it and a queue-based FIFO reference model.
module tb_ram_fifo_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push_valid = 1'b0;
    logic [DATA_W-1:0] push_data = '0;
    logic              push_ready;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic              pop_ready = 1'b0;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_wrenable;
    logic              ram_rdenable;
    logic [DATA_W-1:0] ram_data_out;
`ifdef RAM_FIFO_STATS_EN
    logic              overflow;
    logic [ADDR_W:0]   max_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_data    (push_data),
        .push_ready   (push_ready),
        .pop_valid    (pop_valid),
        .pop_data     (pop_data),
        .pop_ready    (pop_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_wrenable (ram_wrenable),
        .ram_rdenable (ram_rdenable),
        .ram_data_out (ram_data_out)
`ifdef RAM_FIFO_STATS_EN
        ,
        .overflow     (overflow),
        .max_count    (max_count)
`endif
    );

    // Behavioural single-port RAM with registered read data.
    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] ram_q = '0;
    assign ram_data_out = ram_q;
    always @(posedge clk) begin
        if (ram_wrenable) mem[ram_address] <= ram_data_in;
        if (ram_rdenable) ram_q <= mem[ram_address];
    end

    // Reference model: an ordered queue of every word accepted and not yet popped.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] dummy;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (pop_valid && pop_ready && mq.size() > 0) dummy = mq.pop_front();
            if (push_valid && push_ready) mq.push_back(push_data);
        end
    end

    task automatic test_reset();
        push_valid = 1'b1;
        push_data  = 16'hAAAA;
        pop_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ram_wrenable !== 1'b0 || ram_rdenable !== 1'b0 || push_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_strobes cyc=%0d wr=%b rd=%b push_ready=%b required 0/0/0",
                         k, ram_wrenable, ram_rdenable, push_ready);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || push_ready !== 1'b1 ||
            full !== 1'b0 || pop_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_release count=%0d empty=%b pop_valid=%b push_ready=%b full=%b pop_data=%h required 0/1/0/1/0/0000",
                     count, empty, pop_valid, push_ready, full, pop_data);
        end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        push_valid = 1'b1;
        push_data  = 16'h1234;
        pop_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_wrenable !== 1'b1 || ram_address !== 5'd0 || ram_data_in !== 16'h1234 || push_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_write wr=%b addr=%0d din=%h push_ready=%b required 1/0/1234/1",
                     ram_wrenable, ram_address, ram_data_in, push_ready);
        end
        @(posedge clk); #1;
        push_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_rdenable !== 1'b1 || ram_address !== 5'd0 || push_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat_read rd=%b addr=%0d push_ready=%b required 1/0/0",
                     ram_rdenable, ram_address, push_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (pop_valid !== 1'b0 || count !== 6'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL lat_rdwait pop_valid=%b count=%0d empty=%b required 0/1/0", pop_valid, count, empty);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 16'h1234) begin
            errors++;
            $display("FAIL lat_pop pop_valid=%b pop_data=%h required 1/1234", pop_valid, pop_data);
        end
        @(posedge clk); #1;
        pop_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || pop_valid !== 1'b0 || count !== 6'd0 || pop_data !== 16'h1234) begin
            errors++;
            $display("FAIL lat_after empty=%b pop_valid=%b count=%0d pop_data=%h required 1/0/0/1234",
                     empty, pop_valid, count, pop_data);
        end
    endtask

    task automatic test_fill_drain();
        int i = 0;
        int j = 0;
        int cyc = 0;
        pop_ready = 1'b0;
        while (i < 33 && cyc < 300) begin
            @(posedge clk); #1;
            push_valid = 1'b1;
            push_data  = 16'(i);
            @(negedge clk);
            checks++;
            if (count !== 6'(mq.size())) begin
                errors++;
                $display("FAIL fill_count count=%0d required %0d", count, mq.size());
            end
            if (push_ready) i++;
            cyc++;
        end
        checks++;
        if (i != 33) begin
            errors++;
            $display("FAIL fill_timeout accepted=%0d required 33", i);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            push_valid = 1'b1;
            push_data  = 16'hDEAD;
            @(negedge clk);
            checks++;
            if (full !== 1'b1 || push_ready !== 1'b0 || ram_wrenable !== 1'b0 || count !== 6'd33) begin
                errors++;
                $display("FAIL full_hold full=%b push_ready=%b wr=%b count=%0d required 1/0/0/33",
                         full, push_ready, ram_wrenable, count);
            end
        end
        cyc = 0;
        while (j < 33 && cyc < 300) begin
            @(posedge clk); #1;
            push_valid = 1'b0;
            pop_ready  = 1'b1;
            @(negedge clk);
            checks++;
            if (count !== 6'(mq.size())) begin
                errors++;
                $display("FAIL drain_count count=%0d required %0d", count, mq.size());
            end
            if (pop_valid) begin
                checks++;
                if (pop_data !== 16'(j)) begin
                    errors++;
                    $display("FAIL drain_data idx=%0d pop_data=%h required %h", j, pop_data, 16'(j));
                end
                j++;
            end
            cyc++;
        end
        checks++;
        if (j != 33) begin
            errors++;
            $display("FAIL drain_timeout popped=%0d required 33", j);
        end
        @(posedge clk); #1;
        pop_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || pop_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty empty=%b full=%b pop_valid=%b required 1/0/0", empty, full, pop_valid);
        end
    endtask

    // continuous=1: push_valid and pop_ready held high; otherwise random.
    task automatic test_stream(input bit continuous);
        int n_push = 0;
        int n_pop = 0;
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            push_valid = (n_push < 200) && (continuous || $urandom_range(0, 3) != 0);
            push_data  = 16'($urandom);
            pop_ready  = continuous || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (count !== 6'(mq.size()) || empty !== (mq.size() == 0)) begin
                errors++;
                $display("FAIL stream_count count=%0d empty=%b required %0d", count, empty, mq.size());
            end
            checks++;
            if (push_ready !== (!full && !ram_rdenable) || (ram_wrenable && ram_rdenable)) begin
                errors++;
                $display("FAIL stream_port push_ready=%b wr=%b rd=%b full=%b required ready=!full&!rd, not wr&rd",
                         push_ready, ram_wrenable, ram_rdenable, full);
            end
            if (mq.size() == 0) begin
                checks++;
                if (ram_rdenable !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_rd_empty rd=%b required 0", ram_rdenable);
                end
            end
            if (pop_valid && pop_ready) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL stream_pop_extra pop_data=%h required no word", pop_data);
                end else if (pop_data !== mq[0]) begin
                    errors++;
                    $display("FAIL stream_pop_data idx=%0d pop_data=%h required %h", n_pop, pop_data, mq[0]);
                end
                n_pop++;
            end
            if (push_valid && push_ready) n_push++;
            done = (n_push == 200) && (mq.size() == 0) && !(pop_valid && pop_ready);
            cyc++;
        end
        checks++;
        if (!done || n_pop != 200) begin
            errors++;
            $display("FAIL stream_timeout mode=%0d pushed=%0d popped=%0d required 200/200", continuous, n_push, n_pop);
        end
        @(posedge clk); #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
    endtask

    task automatic test_rst_rd_wait();
        int acc = 0;
        int cyc = 0;
        pop_ready = 1'b0;
        while (acc < 6 && cyc < 100) begin
            @(posedge clk); #1;
            push_valid = 1'b1;
            push_data  = 16'h5000 + 16'(acc);
            @(negedge clk);
            if (push_ready) acc++;
            cyc++;
        end
        @(posedge clk); #1;
        push_valid = 1'b0;
        cyc = 0;
        while (!(pop_valid && count == 6'd6) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(pop_valid && count == 6'd6)) begin
            errors++;
            $display("FAIL rst_setup pop_valid=%b count=%0d required 1/6", pop_valid, count);
        end
        @(posedge clk); #1;
        pop_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_rdenable !== 1'b1 || pop_data !== 16'h5000) begin
            errors++;
            $display("FAIL rst_issue rd=%b pop_data=%h required 1/5000", ram_rdenable, pop_data);
        end
        @(posedge clk); #1;
        pop_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 6'd5 || ram_wrenable !== 1'b0 || ram_rdenable !== 1'b0 || push_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_during count=%0d wr=%b rd=%b push_ready=%b required 5/0/0/0",
                     count, ram_wrenable, ram_rdenable, push_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 6'd0 || pop_valid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_after count=%0d pop_valid=%b empty=%b required 0/0/1", count, pop_valid, empty);
        end
        @(posedge clk); #1;
        push_valid = 1'b1;
        push_data  = 16'hBEEF;
        pop_ready  = 1'b1;
        @(posedge clk); #1;
        push_valid = 1'b0;
        cyc = 0;
        while (!pop_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL rst_next_word pop_valid=%b pop_data=%h required 1/beef", pop_valid, pop_data);
        end
        @(posedge clk); #1;
        pop_ready = 1'b0;
        @(negedge clk);
    endtask

`ifdef RAM_FIFO_STATS_EN
    task automatic test_stats();
        int cyc = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || max_count !== 6'd0) begin
            errors++;
            $display("FAIL stats_reset overflow=%b max_count=%0d required 0/0", overflow, max_count);
        end
        pop_ready = 1'b0;
        while (count != 6'd33 && cyc < 200) begin
            @(posedge clk); #1;
            push_valid = 1'b1;
            push_data  = 16'($urandom);
            @(negedge clk);
            cyc++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        push_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || max_count !== 6'd33) begin
            errors++;
            $display("FAIL stats_full overflow=%b max_count=%0d required 1/33", overflow, max_count);
        end
        pop_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || max_count !== 6'd33) begin
            errors++;
            $display("FAIL stats_sticky overflow=%b max_count=%0d required 1/33", overflow, max_count);
        end
        @(posedge clk); #1;
        pop_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || max_count !== 6'd0) begin
            errors++;
            $display("FAIL stats_clear overflow=%b max_count=%0d required 0/0", overflow, max_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_fill_drain();
        test_stream(1'b1);
        test_stream(1'b0);
        test_rst_rd_wait();
`ifdef RAM_FIFO_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
